pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Sequences the 5-stage pipeline around the instruction decoder. It detects load-use, CBZ-operand and BLT-flag hazards on the instruction in ID and stalls or bubbles the pipeline for the required number of cycles. It freezes all stages while data memory is not ready and squashes the fetched instruction on a taken branch. It sits beside the ID-stage decoder and drives the write enables of the PC and every pipeline register.

## Interface
- STALL_MAX, 2, maximum hazard stall length in cycles; sets the stall counter width to 2 bits.
- PERF_W, 32, width of the performance counters (present only with the macro).

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_rn, id_rm  in  5 each  ID register read addresses, taken after the Reg2Loc mux
- id_uses_rn, id_uses_rm  in  1 each  ID instruction reads that operand
- id_is_cbz, id_is_blt  in  1 each  ID instruction is CBZ / BLT
- id_br_taken  in  1  decoder BrTaken for the ID instruction
- ex_rd  in  5  EX destination register
- ex_reg_write, ex_mem_read, ex_flagset  in  1 each  EX control bits
- mem_rd  in  5  MEM destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register write enables
- idex_bubble  out  1  load zeroed control into ID/EX
- ifid_flush  out  1  load NOP into IF/ID
- perf_stall_cnt, perf_flush_cnt  out  PERF_W each  performance counters (macro only)

## Operation
- The FSM has three states: INIT, RUN and HAZ. The stall counter stall_q is 2 bits wide.
- **INIT** (reset state):
  - pc_we, ifid_we, idex_we, exmem_we and memwb_we are 0.
  - idex_bubble and ifid_flush are 1.
  - The FSM moves to RUN on the first clock edge after reset_n rises.
- Register 31 (XZR) never creates a hazard.
- Hazard length is computed in RUN from the instruction in ID:
  - Load-use: ex_mem_read and a used ID operand equals ex_rd. Length is 1.
  - CBZ with an EX producer: id_is_cbz, ex_reg_write and id_rm == ex_rd. Length is 1 if ex_mem_read is 0, 2 if ex_mem_read is 1.
  - CBZ with a MEM load: id_is_cbz, mem_mem_read and id_rm == mem_rd. Length is 1.
  - BLT flags: id_is_blt and ex_flagset. Length is 1.
  - When several conditions apply, the maximum length is used.
- **RUN, hazard length n > 0**:
  - pc_we=0, ifid_we=0, idex_bubble=1. EX/MEM/WB enables stay 1.
  - ifid_flush=0; id_br_taken is ignored.
  - If n is 1, the FSM stays in RUN and re-evaluates next cycle.
  - If n is 2, stall_q loads 1 and the FSM goes to HAZ.
- **HAZ**:
  - The same stall outputs are driven as in RUN.
  - stall_q decrements each cycle. The FSM returns to RUN when stall_q reaches 0.
- **RUN, no hazard, id_br_taken=1**: ifid_flush=1 and every enable is 1.
- **Memory wait** has the highest priority in any non-INIT state. While mem_req=1 and mem_ready=0:
  - Every write enable is 0, and idex_bubble and ifid_flush are 0.
  - The FSM state and stall_q hold their values.
  - Hazard evaluation resumes in the cycle that mem_ready rises.
- Asserting reset_n mid-stall returns the FSM immediately (asynchronously) to INIT and clears stall_q.

## Timing
- Hazard outputs are combinational from the ID/EX/MEM inputs and the current state, and take effect in the same cycle. State and counters update on the rising clock edge.
- Load-use costs 1 bubble cycle.
- CBZ behind a load costs 2 cycles. CBZ behind an ALU producer costs 1 cycle. CBZ whose load producer has already reached MEM costs 1 cycle.
- A taken branch costs 1 flushed fetch.
- A memory wait of k cycles freezes the whole pipeline for exactly k cycles.
- mem_ready is sampled only while mem_req=1.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_stall_cnt increments each cycle that idex_bubble=1 outside INIT.
  - perf_flush_cnt increments each cycle that ifid_flush=1 outside INIT.
  - Both counters saturate at all-ones and reset to 0.
- HAZARD_PERF_CNT_EN undefined: both ports and all counter logic are absent.

## Test plan
- Reset, then release reset_n: during reset every enable is 0 and bubble/flush are 1. All enables are 1 on the first cycle after the first edge following release.
- LDUR X1 in EX, ADD X2,X1,X3 in ID: exactly 1 cycle with pc_we=0 and idex_bubble=1, then normal flow. The same sequence with X31 as the destination: no stall.
- LDUR X4 in EX, CBZ X4 in ID: 2 stall cycles (RUN→HAZ→RUN), then id_br_taken=1 gives ifid_flush=1 for 1 cycle.
- SUBS in EX, BLT in ID: 1 stall cycle, and ifid_flush stays 0 during the stall.
- mem_req=1 with mem_ready held low 3 cycles, injected during HAZ: all enables are 0 for 3 cycles, stall_q is preserved, and the stall then completes.
- With the macro defined, 5 loads each followed by a dependent instruction: perf_stall_cnt equals 5. After the counter is preloaded near saturation, it holds at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline control outputs for pipe_hazard_ctrl.
// The master modport is the pipeline/decoder side; the slave modport is the hazard controller.
interface pipe_hazard_ctrl_if;

    // ID-stage operand and branch information
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic       id_is_cbz;
    logic       id_is_blt;
    logic       id_br_taken;

    // EX-stage producer information
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_flagset;

    // MEM-stage producer and data-memory handshake
    logic [4:0] mem_rd;
    logic       mem_mem_read;
    logic       mem_req;
    logic       mem_ready;

    // Pipeline register controls
    logic       pc_we;
    logic       ifid_we;
    logic       idex_we;
    logic       exmem_we;
    logic       memwb_we;
    logic       idex_bubble;
    logic       ifid_flush;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_blt, id_br_taken,
        output ex_rd, ex_reg_write, ex_mem_read, ex_flagset,
        output mem_rd, mem_mem_read, mem_req, mem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we, idex_bubble, ifid_flush
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_cbz, id_is_blt, id_br_taken,
        input  ex_rd, ex_reg_write, ex_mem_read, ex_flagset,
        input  mem_rd, mem_mem_read, mem_req, mem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we, idex_bubble, ifid_flush
    );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage pipeline: load-use, CBZ-operand and
// BLT-flag stalls, memory-wait freeze and taken-branch fetch squash.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned STALL_MAX = 2
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W    = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipe_hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]    perf_stall_cnt,
    output logic [PERF_W-1:0]    perf_flush_cnt
`endif
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
    localparam logic [4:0]  XZR     = 5'd31;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HAZ  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [STALL_W-1:0]   stall_q;
    logic [STALL_W-1:0]   stall_d;

    logic                 rn_hit_ex;
    logic                 rm_hit_ex;
    logic                 rm_hit_mem;
    logic                 load_use;
    logic                 cbz_ex;
    logic                 cbz_mem;
    logic                 blt_flag;
    logic                 mem_wait;
    logic [STALL_W-1:0]   haz_len;

    logic                 pc_we;
    logic                 ifid_we;
    logic                 idex_we;
    logic                 exmem_we;
    logic                 memwb_we;
    logic                 idex_bubble;
    logic                 ifid_flush;

    // Operand match terms; XZR never forms a dependency
    always_comb begin
        rn_hit_ex  = hz.id_uses_rn && (hz.id_rn != XZR) && (hz.id_rn == hz.ex_rd);
        rm_hit_ex  = hz.id_uses_rm && (hz.id_rm != XZR) && (hz.id_rm == hz.ex_rd);
        rm_hit_mem = (hz.id_rm != XZR) && (hz.id_rm == hz.mem_rd);
        load_use   = hz.ex_mem_read && (rn_hit_ex || rm_hit_ex);
        cbz_ex     = hz.id_is_cbz && hz.ex_reg_write && (hz.id_rm != XZR) && (hz.id_rm == hz.ex_rd);
        cbz_mem    = hz.id_is_cbz && hz.mem_mem_read && rm_hit_mem;
        blt_flag   = hz.id_is_blt && hz.ex_flagset;
        mem_wait   = hz.mem_req && !hz.mem_ready;
    end

    // Hazard length: the longest of all applicable conditions
    always_comb begin
        haz_len = '0;
        if (load_use || cbz_ex || cbz_mem || blt_flag) begin
            haz_len = STALL_W'(1);
        end
        if (cbz_ex && hz.ex_mem_read) begin
            haz_len = STALL_W'(2);
        end
    end

    // State and stall counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_we    = 1'b0;
                idex_bubble = 1'b1;
                ifid_flush  = 1'b1;
                state_d     = ST_RUN;
            end

            ST_RUN: begin
                if (mem_wait) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                    memwb_we = 1'b0;
                end else if (haz_len != '0) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    if (haz_len > STALL_W'(1)) begin
                        stall_d = haz_len - STALL_W'(1);
                        state_d = ST_HAZ;
                    end
                end else if (hz.id_br_taken) begin
                    ifid_flush = 1'b1;
                end
            end

            ST_HAZ: begin
                if (mem_wait) begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                    memwb_we = 1'b0;
                end else begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    stall_d     = stall_q - STALL_W'(1);
                    if (stall_q <= STALL_W'(1)) begin
                        stall_d = '0;
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
                stall_d = '0;
            end
        endcase
    end

    assign hz.pc_we       = pc_we;
    assign hz.ifid_we     = ifid_we;
    assign hz.idex_we     = idex_we;
    assign hz.exmem_we    = exmem_we;
    assign hz.memwb_we    = memwb_we;
    assign hz.idex_bubble = idex_bubble;
    assign hz.ifid_flush  = ifid_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;

    // Saturating bubble/flush counters, counting only once the pipeline runs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if ((state_q != ST_INIT) && idex_bubble && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
            if ((state_q != ST_INIT) && ifid_flush && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl; output vector order is
// {pc_we, ifid_we, idex_we, exmem_we, memwb_we, idex_bubble, ifid_flush}.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] O_INIT   = 7'b00000_11;
    localparam logic [6:0] O_RUN    = 7'b11111_00;
    localparam logic [6:0] O_STALL  = 7'b00111_10;
    localparam logic [6:0] O_FLUSH  = 7'b11111_01;
    localparam logic [6:0] O_FREEZE = 7'b00000_00;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0] perf_stall_cnt;
    logic [2:0] perf_flush_cnt;

    pipe_hazard_ctrl #(.STALL_MAX(2), .PERF_W(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hz             (bus),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`else
    pipe_hazard_ctrl #(.STALL_MAX(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (bus)
    );
`endif

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
                    bus.idex_bubble, bus.ifid_flush});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rn        = 5'd0;
        bus.id_rm        = 5'd0;
        bus.id_uses_rn   = 1'b0;
        bus.id_uses_rm   = 1'b0;
        bus.id_is_cbz    = 1'b0;
        bus.id_is_blt    = 1'b0;
        bus.id_br_taken  = 1'b0;
        bus.ex_rd        = 5'd0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_flagset   = 1'b0;
        bus.mem_rd       = 5'd0;
        bus.mem_mem_read = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
    endtask

    // LDUR Xd in EX, ADD X2,Xd,X3 in ID
    task automatic set_load_use(input logic [4:0] rd);
        clr();
        bus.ex_rd        = rd;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.id_rn        = rd;
        bus.id_rm        = 5'd3;
        bus.id_uses_rn   = 1'b1;
        bus.id_uses_rm   = 1'b1;
    endtask

    // LDUR X4 in EX, CBZ X4 in ID
    task automatic set_cbz_load();
        clr();
        bus.ex_rd        = 5'd4;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_read  = 1'b1;
        bus.id_rm        = 5'd4;
        bus.id_uses_rm   = 1'b1;
        bus.id_is_cbz    = 1'b1;
    endtask

    // Load has advanced to MEM while CBZ stays in ID
    task automatic set_cbz_mem();
        clr();
        bus.mem_rd       = 5'd4;
        bus.mem_mem_read = 1'b1;
        bus.id_rm        = 5'd4;
        bus.id_uses_rm   = 1'b1;
        bus.id_is_cbz    = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        clr();

        // Reset and release
        step();
        step();
        check("reset_outputs", outs(), 32'(O_INIT));
        reset_n = 1'b1;
        #1;
        check("released_before_edge", outs(), 32'(O_INIT));
        step();
        check("run_after_release", outs(), 32'(O_RUN));

        // Load-use: one bubble then normal flow
        set_load_use(5'd1);
        #1;
        check("load_use_stall", outs(), 32'(O_STALL));
        step();
        clr();
        #1;
        check("load_use_resume", outs(), 32'(O_RUN));

        // Same sequence targeting XZR: no stall
        set_load_use(5'd31);
        #1;
        check("xzr_no_stall", outs(), 32'(O_RUN));
        step();

        // CBZ behind a load: two stall cycles then taken branch flush
        set_cbz_load();
        #1;
        check("cbz_load_stall1", outs(), 32'(O_STALL));
        step();
        set_cbz_mem();
        bus.id_br_taken = 1'b1;
        #1;
        check("cbz_load_stall2", outs(), 32'(O_STALL));
        step();
        clr();
        bus.id_is_cbz   = 1'b1;
        bus.id_rm       = 5'd4;
        bus.id_uses_rm  = 1'b1;
        bus.id_br_taken = 1'b1;
        #1;
        check("cbz_taken_flush", outs(), 32'(O_FLUSH));
        step();
        clr();
        #1;
        check("after_flush", outs(), 32'(O_RUN));

        // CBZ behind ALU producer: one stall
        set_cbz_load();
        bus.ex_mem_read = 1'b0;
        #1;
        check("cbz_alu_stall", outs(), 32'(O_STALL));
        step();
        clr();
        #1;
        check("cbz_alu_resume", outs(), 32'(O_RUN));

        // CBZ with load already in MEM: one stall
        set_cbz_mem();
        #1;
        check("cbz_mem_stall", outs(), 32'(O_STALL));
        step();
        clr();
        #1;
        check("cbz_mem_resume", outs(), 32'(O_RUN));

        // BLT behind SUBS: stall without flush even if branch resolves taken
        clr();
        bus.id_is_blt   = 1'b1;
        bus.ex_flagset  = 1'b1;
        bus.id_br_taken = 1'b1;
        #1;
        check("blt_stall_no_flush", outs(), 32'(O_STALL));
        step();
        bus.ex_flagset = 1'b0;
        #1;
        check("blt_taken_flush", outs(), 32'(O_FLUSH));
        step();

        // Memory wait beats a pending hazard in RUN
        set_load_use(5'd7);
        bus.mem_req = 1'b1;
        #1;
        check("memwait_over_hazard", outs(), 32'(O_FREEZE));
        bus.mem_ready = 1'b1;
        #1;
        check("memready_hazard", outs(), 32'(O_STALL));
        step();

        // mem_ready ignored while mem_req is low
        clr();
        #1;
        check("no_req_no_freeze", outs(), 32'(O_RUN));

        // Memory wait of 3 cycles injected in HAZ; stall then finishes
        set_cbz_load();
        #1;
        check("haz_entry", outs(), 32'(O_STALL));
        step();
        set_cbz_mem();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("haz_freeze%0d", i), outs(), 32'(O_FREEZE));
            step();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("haz_after_wait", outs(), 32'(O_STALL));
        step();
        clr();
        #1;
        check("haz_done", outs(), 32'(O_RUN));

        // Asynchronous reset mid-stall
        set_cbz_load();
        step();
        set_cbz_mem();
        #1;
        check("pre_reset_haz", outs(), 32'(O_STALL));
        reset_n = 1'b0;
        #1;
        check("async_reset", outs(), 32'(O_INIT));
        step();
        reset_n = 1'b1;
        clr();
        #1;
        check("reset_hold_init", outs(), 32'(O_INIT));
        step();
        check("reset_resume", outs(), 32'(O_RUN));

`ifdef HAZARD_PERF_CNT_EN
        // Performance counters (3-bit instance saturates at 7)
        check("perf_stall_zero", 32'(perf_stall_cnt), 32'd0);
        check("perf_flush_zero", 32'(perf_flush_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_load_use(5'd9);
            step();
            clr();
            step();
        end
        check("perf_stall_five", 32'(perf_stall_cnt), 32'd5);
        for (int i = 0; i < 5; i++) begin
            set_load_use(5'd9);
            step();
            clr();
            step();
        end
        check("perf_stall_sat", 32'(perf_stall_cnt), 32'd7);
        bus.id_br_taken = 1'b1;
        step();
        clr();
        check("perf_flush_one", 32'(perf_flush_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
